// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - two-port arbiter and strobe sequencer for a 4Kx8 asynchronous RAM
//
// Shares one asynchronous RAM between two requesters and turns each granted access
// into an IDLE -> SETUP -> STROBE(xSTROBE_CYCLES) -> HOLD sequence. Every RAM-side
// output comes from a flop, so the strobes never glitch. Reset releases the strobes
// and tri-states the bus without waiting for a clock.
//
// Ports:
//   clk, notReset                    clock (rising edge), asynchronous active-low reset
//   req0/1, we0/1, addr0/1, wdata0/1 requester side; fields are captured at grant
//   ack0/1                           one-cycle completion pulse (HOLD cycle)
//   rdata0/1                         read data, updated only by reads on that port
//   busy                             high whenever the sequencer is not IDLE
//   ramAddress, ramNot*Enable, ramIo RAM side: address, active-low strobes, data bus

module ram_access_arbiter #(
    parameter int ADDR_W        = 12,
    parameter int DATA_W        = 8,
    parameter int STROBE_CYCLES = 2,
    parameter int FAIR          = 1
) (
    input  logic              clk,
    input  logic              notReset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] ramAddress,
    output logic              ramNotChipEnable,
    output logic              ramNotOutputEnable,
    output logic              ramNotWriteEnable,
    inout  wire  [DATA_W-1:0] ramIo
);

    if (STROBE_CYCLES < 1) begin : gBadStrobeCycles
        $error("ram_access_arbiter: STROBE_CYCLES must be >= 1");
    end

    localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   strobeCnt;
    logic               grantPort;
    logic               lastGrant;
    logic               latchedWe;
    logic [DATA_W-1:0]  latchedWdata;
    logic               driveBus;
    logic               pickPort;

    // Only the tie case consults FAIR; a lone request is always granted.
    always_comb begin
        pickPort = 1'b0;
        if (req0 && req1) begin
            pickPort = (FAIR != 0) ? !lastGrant : 1'b0;
        end else if (req1) begin
            pickPort = 1'b1;
        end
    end

    // driveBus is a flop cleared by the async reset, so the bus floats the moment
    // notReset falls even in the middle of a write.
    assign ramIo = driveBus ? latchedWdata : {DATA_W{1'bz}};
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            state              <= IDLE;
            strobeCnt          <= '0;
            grantPort          <= 1'b0;
            lastGrant          <= 1'b1;
            latchedWe          <= 1'b0;
            latchedWdata       <= '0;
            driveBus           <= 1'b0;
            ack0               <= 1'b0;
            ack1               <= 1'b0;
            rdata0             <= '0;
            rdata1             <= '0;
            ramAddress         <= '0;
            ramNotChipEnable   <= 1'b1;
            ramNotOutputEnable <= 1'b1;
            ramNotWriteEnable  <= 1'b1;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grantPort        <= pickPort;
                        lastGrant        <= pickPort;
                        latchedWe        <= pickPort ? we1 : we0;
                        latchedWdata     <= pickPort ? wdata1 : wdata0;
                        ramAddress       <= pickPort ? addr1 : addr0;
                        ramNotChipEnable <= 1'b0;
                        // Write data goes onto the bus during SETUP so it is stable
                        // before ramNotWriteEnable falls.
                        driveBus         <= pickPort ? we1 : we0;
                        state            <= SETUP;
                    end
                end
                SETUP: begin
                    strobeCnt <= CNT_W'(STROBE_CYCLES - 1);
                    if (latchedWe) begin
                        ramNotWriteEnable <= 1'b0;
                    end else begin
                        ramNotOutputEnable <= 1'b0;
                    end
                    state <= STROBE;
                end
                STROBE: begin
                    if (strobeCnt == '0) begin
                        ramNotWriteEnable  <= 1'b1;
                        ramNotOutputEnable <= 1'b1;
                        // Sample on the same edge that releases nOE: the RAM output
                        // is still valid here.
                        if (!latchedWe) begin
                            if (grantPort) begin
                                rdata1 <= ramIo;
                            end else begin
                                rdata0 <= ramIo;
                            end
                        end
                        ack0  <= !grantPort;
                        ack1  <= grantPort;
                        state <= HOLD;
                    end else begin
                        strobeCnt <= strobeCnt - 1'b1;
                    end
                end
                HOLD: begin
                    ramNotChipEnable <= 1'b1;
                    driveBus         <= 1'b0;
                    state            <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
